// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and its
// in-flight destination scoreboard.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  memRead;
        logic [REG_ADDR_W-1:0] waddr;
    } sb_entry_t;

    function automatic logic entryMatches(sb_entry_t e, logic [REG_ADDR_W-1:0] addr);
        return e.valid && (e.waddr == addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Three-entry shift register tracking the destinations of instructions in
// EX, MEM and WB, with a read-after-write compare port for the ID stage.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_shift,
    input  logic                  i_bubble,
    input  logic                  i_kill,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic                  i_mem_read,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic                  i_uses_rt,
    output logic                  o_hazard,
    output logic                  o_empty
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;
    sb_entry_t w_load;
    logic      w_rsHit;
    logic      w_rtHit;

    // Invalid entries are kept all-zero, so emptiness is a whole-entry test.
    always_comb begin
        w_load = '0;
        if (i_wr_en && (i_waddr != '0) && !i_bubble && !i_kill) begin
            w_load.valid   = 1'b1;
            w_load.memRead = i_mem_read;
            w_load.waddr   = i_waddr;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (i_shift) begin
            r_wb  <= r_mem;
            r_mem <= i_kill ? '0 : r_ex;
            r_ex  <= w_load;
        end
    end

    // WB still counts: the register file only writes at the end of that cycle.
    assign w_rsHit = (i_rs != '0) &&
                     (entryMatches(r_ex, i_rs) || entryMatches(r_mem, i_rs) ||
                      entryMatches(r_wb, i_rs));
    assign w_rtHit = i_uses_rt && (i_rt != '0) &&
                     (entryMatches(r_ex, i_rt) || entryMatches(r_mem, i_rt) ||
                      entryMatches(r_wb, i_rt));

    assign o_hazard = w_rsHit || w_rtHit;
    assign o_empty  = ({r_ex, r_mem, r_wb} == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: RAW stalls, MEM-stage
// redirect flushes and a run/drain/halt state machine.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  halt_req,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  mem_branch,
    input  logic                  mem_zero,
    input  logic                  mem_jump,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  stall,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    ctrl_state_t      r_state;
    logic             r_drainPending;
    logic             r_idValid;
    logic [CNT_W-1:0] r_stallCnt;

    logic w_active;
    logic w_redirect;
    logic w_sbHazard;
    logic w_sbEmpty;
    logic w_stall;

    // A low enable freezes the pipeline immediately, even before the state leaves RUN/DRAIN.
    assign w_active   = enable && ((r_state == RUN) || (r_state == DRAIN));
    assign w_redirect = w_active && ((mem_branch && mem_zero) || mem_jump);
    assign w_stall    = w_active && r_idValid && w_sbHazard && !w_redirect;

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_shift    (w_active),
        .i_bubble   (w_stall),
        .i_kill     (w_redirect),
        .i_wr_en    (r_idValid && id_reg_write),
        .i_waddr    (id_waddr),
        .i_mem_read (id_mem_read),
        .i_rs       (id_rs),
        .i_rt       (id_rt),
        .i_uses_rt  (id_uses_rt),
        .o_hazard   (w_sbHazard),
        .o_empty    (w_sbEmpty)
    );

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall       = 1'b0;
        if (w_redirect) begin
            pc_en       = (r_state == RUN);
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_stall) begin
            idex_flush = 1'b1;
            stall      = 1'b1;
        end else if (w_active) begin
            ifid_en    = 1'b1;
            pc_en      = (r_state == RUN);
            ifid_flush = (r_state == DRAIN);
        end
    end

    // Once draining has begun the core never returns to RUN before a reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= IDLE;
            r_drainPending <= 1'b0;
            halted         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= r_drainPending ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (halt_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!enable) begin
                        r_state        <= IDLE;
                        r_drainPending <= 1'b1;
                    end else if (w_sbEmpty && !r_idValid) begin
                        r_state <= HALTED;
                        halted  <= 1'b1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idValid <= 1'b0;
        end else if (w_active) begin
            if (w_redirect) begin
                r_idValid <= 1'b0;
            end else if (!w_stall) begin
                r_idValid <= (r_state == RUN);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule
